// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel decoder: hunts for the 10-bit word boundary using control tokens,
// then decodes aligned words into video bytes, control pairs and TERC4 nibbles.
module tmds_channel_decoder #(
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned SEARCH_CYCLES = 4096,
  parameter int unsigned LOSS_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] raw_in,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic [3:0] terc4,
  output logic       terc4_hit
);

  localparam int unsigned TokW    = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SearchW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int unsigned IdleW   = $clog2(LOSS_CYCLES + 1);

  localparam logic [TokW-1:0]    LockVal    = TokW'(LOCK_COUNT);
  localparam logic [SearchW-1:0] SearchLast = SearchW'(SEARCH_CYCLES - 1);
  localparam logic [IdleW-1:0]   LossVal    = IdleW'(LOSS_CYCLES);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  // {hit, c1, c0}
  function automatic logic [2:0] ctrl_lookup(input logic [9:0] x);
    case (x)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // {hit, nibble}
  function automatic logic [4:0] terc4_lookup(input logic [9:0] x);
    case (x)
      10'h29C: return 5'h10;
      10'h263: return 5'h11;
      10'h2E4: return 5'h12;
      10'h2E2: return 5'h13;
      10'h171: return 5'h14;
      10'h11E: return 5'h15;
      10'h18E: return 5'h16;
      10'h13C: return 5'h17;
      10'h2CC: return 5'h18;
      10'h139: return 5'h19;
      10'h19C: return 5'h1A;
      10'h2C6: return 5'h1B;
      10'h28E: return 5'h1C;
      10'h271: return 5'h1D;
      10'h163: return 5'h1E;
      10'h2C3: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] video_decode(input logic [9:0] x);
    logic [7:0] q;
    logic [7:0] d;
    q    = x[9] ? ~x[7:0] : x[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = x[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_e             state_q, state_d;
  logic [9:0]         prev_q, w_q, w_d;
  logic [3:0]         offset_q, offset_d;
  logic [TokW-1:0]    tok_cnt_q, tok_cnt_d, tok_inc;
  logic [SearchW-1:0] search_cnt_q, search_cnt_d;
  logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d, idle_inc;
  logic               locked_q, locked_d, de_q, de_d, terc4_hit_q, terc4_hit_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [7:0]         data_q, data_d;
  logic [3:0]         terc4_q, terc4_d;
  logic [2:0]         tok_info;
  logic [4:0]         terc_info;
  logic               is_tok;

  // Earlier word sits in the low half, so offset 0 selects the previous raw word.
  always_comb begin
    w_d = 10'({raw_in, prev_q} >> offset_q);
  end

  always_comb begin
    tok_info  = ctrl_lookup(w_q);
    terc_info = terc4_lookup(w_q);
    is_tok    = tok_info[2];
    tok_inc   = tok_cnt_q + 1'b1;
    idle_inc  = idle_cnt_q + 1'b1;

    state_d      = state_q;
    offset_d     = offset_q;
    tok_cnt_d    = tok_cnt_q;
    search_cnt_d = search_cnt_q;
    idle_cnt_d   = idle_cnt_q;

    unique case (state_q)
      StHunt: begin
        tok_cnt_d    = is_tok ? tok_inc : '0;
        search_cnt_d = search_cnt_q + 1'b1;
        if (is_tok && tok_inc == LockVal) begin
          state_d      = StLocked;
          tok_cnt_d    = '0;
          search_cnt_d = '0;
          idle_cnt_d   = '0;
        end else if (search_cnt_q == SearchLast) begin
          offset_d     = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          tok_cnt_d    = '0;
          search_cnt_d = '0;
        end
      end
      StLocked: begin
        idle_cnt_d = is_tok ? '0 : idle_inc;
        if (!is_tok && idle_inc == LossVal) begin
          state_d      = StHunt;
          tok_cnt_d    = '0;
          search_cnt_d = '0;
          idle_cnt_d   = '0;
        end
      end
    endcase

    locked_d    = 1'b0;
    de_d        = 1'b0;
    ctrl_d      = 2'b00;
    data_d      = 8'h00;
    terc4_d     = 4'h0;
    terc4_hit_d = 1'b0;
    if (state_q == StLocked) begin
      locked_d    = 1'b1;
      terc4_hit_d = terc_info[4];
      terc4_d     = terc_info[3:0];
      if (is_tok) begin
        ctrl_d = tok_info[1:0];
      end else begin
        de_d   = 1'b1;
        data_d = video_decode(w_q);
        ctrl_d = ctrl_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StHunt;
      prev_q       <= '0;
      w_q          <= '0;
      offset_q     <= '0;
      tok_cnt_q    <= '0;
      search_cnt_q <= '0;
      idle_cnt_q   <= '0;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      ctrl_q       <= 2'b00;
      data_q       <= 8'h00;
      terc4_q      <= 4'h0;
      terc4_hit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= raw_in;
      w_q          <= w_d;
      offset_q     <= offset_d;
      tok_cnt_q    <= tok_cnt_d;
      search_cnt_q <= search_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      locked_q     <= locked_d;
      de_q         <= de_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      terc4_q      <= terc4_d;
      terc4_hit_q  <= terc4_hit_d;
    end
  end

  assign locked     = locked_q;
  assign bit_offset = offset_q;
  assign de         = de_q;
  assign ctrl       = ctrl_q;
  assign data       = data_q;
  assign terc4      = terc4_q;
  assign terc4_hit  = terc4_hit_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, lock, control/video/TERC4 decode,
// loss of lock, boundary search at offset 3 and asynchronous reset while locked.
module tb_tmds_channel_decoder;

  logic       clk;
  logic       reset_n;
  logic [9:0] raw_in;
  logic       locked;
  logic [3:0] bit_offset;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic [3:0] terc4;
  logic       terc4_hit;

  int checks;
  int errors;

  tmds_channel_decoder #(
    .LOCK_COUNT   (8),
    .SEARCH_CYCLES(16),
    .LOSS_CYCLES  (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .locked    (locked),
    .bit_offset(bit_offset),
    .de        (de),
    .ctrl      (ctrl),
    .data      (data),
    .terc4     (terc4),
    .terc4_hit (terc4_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [9:0] word);
    raw_in = word;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    raw_in  = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      raw_in = 10'($urandom);
      @(posedge clk);
      #1;
    end
    checks++;
    if ({locked, bit_offset, de, ctrl, data, terc4, terc4_hit} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {locked, bit_offset, de, ctrl, data, terc4, terc4_hit});
    end
    reset_n = 1'b1;
  endtask

  task automatic lock_at_zero();
    int n;
    apply_reset();
    n = 0;
    while (locked !== 1'b1 && n < 40) begin
      step(10'h354);
      n++;
    end
    checks++;
    if (locked !== 1'b1 || bit_offset !== 4'd0) begin
      errors++;
      $display("FAIL lock_offset0: locked=%b offset=%0d required locked=1 offset=0",
               locked, bit_offset);
    end
  endtask

  task automatic test_control();
    step(10'h354);
    step(10'h0AB);
    step(10'h154);
    checks++;
    if ({de, ctrl, data} !== 11'b0_00_00000000) begin
      errors++; $display("FAIL ctrl_00: de/ctrl/data=%b required 0_00_0", {de, ctrl, data});
    end
    step(10'h2AB);
    checks++;
    if ({de, ctrl, data} !== 11'b0_01_00000000) begin
      errors++; $display("FAIL ctrl_01: de/ctrl/data=%b required 0_01_0", {de, ctrl, data});
    end
    step(10'h354);
    checks++;
    if ({de, ctrl, data} !== 11'b0_10_00000000) begin
      errors++; $display("FAIL ctrl_10: de/ctrl/data=%b required 0_10_0", {de, ctrl, data});
    end
    step(10'h354);
    checks++;
    if ({de, ctrl, data} !== 11'b0_11_00000000) begin
      errors++; $display("FAIL ctrl_11: de/ctrl/data=%b required 0_11_0", {de, ctrl, data});
    end
  endtask

  task automatic test_video();
    step(10'h2AB);
    step(10'h2FF);
    step(10'h100);
    checks++;
    if ({de, ctrl} !== 3'b0_11) begin
      errors++; $display("FAIL video_pre_ctrl: de/ctrl=%b required 0_11", {de, ctrl});
    end
    step(10'h354);
    checks++;
    if ({de, ctrl, data} !== {1'b1, 2'b11, 8'hFE}) begin
      errors++;
      $display("FAIL video_2ff: de=%b ctrl=%b data=%h required de=1 ctrl=11 data=fe",
               de, ctrl, data);
    end
    step(10'h354);
    checks++;
    if ({de, ctrl, data} !== {1'b1, 2'b11, 8'h00}) begin
      errors++;
      $display("FAIL video_100: de=%b ctrl=%b data=%h required de=1 ctrl=11 data=00",
               de, ctrl, data);
    end
  endtask

  task automatic test_terc4();
    step(10'h29C);
    step(10'h2C3);
    step(10'h2FF);
    checks++;
    if ({de, terc4_hit, terc4} !== 6'b1_1_0000) begin
      errors++;
      $display("FAIL terc4_29c: de=%b hit=%b nib=%h required de=1 hit=1 nib=0",
               de, terc4_hit, terc4);
    end
    step(10'h354);
    checks++;
    if ({terc4_hit, terc4} !== 5'b1_1111) begin
      errors++; $display("FAIL terc4_2c3: hit=%b nib=%h required hit=1 nib=f", terc4_hit, terc4);
    end
    step(10'h354);
    checks++;
    if ({terc4_hit, terc4} !== 5'b0_0000) begin
      errors++; $display("FAIL terc4_miss: hit=%b nib=%h required hit=0 nib=0", terc4_hit, terc4);
    end
  endtask

  task automatic test_loss();
    int n;
    // 32nd idle word drops lock; two pipeline stages plus the state register delay the output.
    for (int i = 0; i < 34; i++) step(10'h2FF);
    checks++;
    if ({locked, de} !== 2'b11) begin
      errors++; $display("FAIL loss_before: locked/de=%b required 11", {locked, de});
    end
    step(10'h2FF);
    checks++;
    if ({locked, de, data, bit_offset} !== {2'b00, 8'h00, 4'd0}) begin
      errors++;
      $display("FAIL loss_drop: locked=%b de=%b data=%h offset=%0d required 0 0 00 0",
               locked, de, data, bit_offset);
    end
    for (int i = 0; i < 8; i++) step(10'h354);
    n = 0;
    while (locked !== 1'b1 && n < 10) begin
      step(10'h354);
      n++;
    end
    checks++;
    if (locked !== 1'b1 || bit_offset !== 4'd0) begin
      errors++;
      $display("FAIL relock: locked=%b offset=%0d required locked=1 offset=0", locked, bit_offset);
    end
  endtask

  task automatic test_alignment();
    logic [9:0] tok;
    logic [9:0] aw;
    logic [3:0] last;
    logic [3:0] want;
    int         n;
    int         slips;
    tok = 10'h354;
    // Serial stream rotated so the token starts at bit 3 of each raw word.
    aw  = {tok[6:0], tok[9:7]};
    apply_reset();
    last  = 4'd0;
    want  = 4'd1;
    slips = 0;
    n     = 0;
    while (locked !== 1'b1 && n < 200) begin
      step(aw);
      n++;
      if (bit_offset !== last) begin
        checks++;
        if (bit_offset !== want) begin
          errors++; $display("FAIL align_step: offset=%0d required %0d", bit_offset, want);
        end
        last = bit_offset;
        want = want + 4'd1;
        slips++;
      end
    end
    checks++;
    if (locked !== 1'b1 || bit_offset !== 4'd3 || slips !== 3) begin
      errors++;
      $display("FAIL align_lock: locked=%b offset=%0d slips=%0d required 1 3 3",
               locked, bit_offset, slips);
    end
    checks++;
    if ({ctrl, de} !== 3'b00_0) begin
      errors++; $display("FAIL align_ctrl: ctrl/de=%b required 00_0", {ctrl, de});
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(aw);
      if (bit_offset !== 4'd3 || locked !== 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL align_stable: %0d unstable cycles required 0", n);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({locked, bit_offset, de, ctrl, data, terc4, terc4_hit} !== 22'h0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0",
               {locked, bit_offset, de, ctrl, data, terc4, terc4_hit});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    raw_in  = 10'h000;
    test_reset();
    lock_at_zero();
    test_control();
    test_video();
    test_terc4();
    test_loss();
    test_alignment();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
